// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared definitions for the output router: default psum lane geometry, the
// collection FSM state encoding and the per-lane wrapping add used when
// accumulating a new psum vector onto a word that is already in the SRAM.
// -----------------------------------------------------------------------------
package router_pkg;

  localparam int PSUM_WIDTH   = 16;
  localparam int ROUTER_COUNT = 4;
  localparam int VEC_WIDTH    = PSUM_WIDTH * ROUTER_COUNT;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    RD    = 3'd2,
    ADD   = 3'd3,
    WR    = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Each lane wraps modulo 2**PSUM_WIDTH. Lanes are added separately so that
  // a carry out of one lane never spills into its neighbour.
  function automatic logic [VEC_WIDTH-1:0] lane_add(input logic [VEC_WIDTH-1:0] a,
                                                    input logic [VEC_WIDTH-1:0] b);
    logic [VEC_WIDTH-1:0] sum;
    sum = '0;
    for (int k = 0; k < ROUTER_COUNT; k++) begin
      sum[k*PSUM_WIDTH +: PSUM_WIDTH] = a[k*PSUM_WIDTH +: PSUM_WIDTH] + b[k*PSUM_WIDTH +: PSUM_WIDTH];
    end
    return sum;
  endfunction

endpackage

// File: rtl/output_sram.sv
// -----------------------------------------------------------------------------
// output_sram
// Simple dual-port RAM: one write port and one registered read port with a
// read latency of one cycle.
//   i_clk               clock, rising edge
//   i_wr_en/addr/data   write port
//   i_rd_en/addr        read request, data appears on o_rd_data next cycle
//   o_rd_data           registered read data (holds between reads)
// -----------------------------------------------------------------------------
module output_sram #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // NOTE: the array has no reset so it maps onto a RAM macro; a reset would
  // force it into flops. Contents are undefined until written.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/output_router.sv
// -----------------------------------------------------------------------------
// output_router
// Collects row-parallel psum vectors from the systolic array and writes one
// packed vector per SRAM word at sequential addresses, either overwriting or
// read-modify-write accumulating. The host reads results back when idle/done.
//   i_clk, i_nrst          clock, async active-low reset
//   i_reg_clear            sync clear of FSM, counters and flags
//   i_en, i_accumulate     start a run / run mode (latched at start)
//   i_start_addr, i_addr_end  inclusive write address range (latched at start)
//   i_psum_valid, i_psum, o_psum_ready  psum vector handshake
//   i_read_en, i_read_addr, o_read_data, o_read_valid  host read port
//   o_busy, o_done, o_write_count  run status
// -----------------------------------------------------------------------------
module output_router #(
  parameter int ROUTER_COUNT    = router_pkg::ROUTER_COUNT,
  parameter int PSUM_WIDTH      = router_pkg::PSUM_WIDTH,
  parameter int SRAM_DATA_WIDTH = ROUTER_COUNT * PSUM_WIDTH,
  parameter int ADDR_WIDTH      = 8
) (
  input  logic                               i_clk,
  input  logic                               i_nrst,
  input  logic                               i_reg_clear,
  input  logic                               i_en,
  input  logic                               i_accumulate,
  input  logic [ADDR_WIDTH-1:0]              i_start_addr,
  input  logic [ADDR_WIDTH-1:0]              i_addr_end,
  input  logic                               i_psum_valid,
  input  logic [ROUTER_COUNT*PSUM_WIDTH-1:0] i_psum,
  output logic                               o_psum_ready,
  input  logic                               i_read_en,
  input  logic [ADDR_WIDTH-1:0]              i_read_addr,
  output logic [SRAM_DATA_WIDTH-1:0]         o_read_data,
  output logic                               o_read_valid,
  output logic                               o_busy,
  output logic                               o_done,
  output logic [ADDR_WIDTH:0]                o_write_count
);

  import router_pkg::*;

  state_t                     r_state, w_state_next;
  logic                       r_accum;
  logic [ADDR_WIDTH-1:0]      r_wr_addr, r_end_addr;
  logic [SRAM_DATA_WIDTH-1:0] r_hold;
  logic [ADDR_WIDTH:0]        r_write_count;
  logic                       r_read_valid;
  logic [SRAM_DATA_WIDTH-1:0] r_read_last;

  logic                       w_host_rd, w_sram_rd_en, w_sram_wr_en;
  logic [ADDR_WIDTH-1:0]      w_sram_rd_addr;
  logic [SRAM_DATA_WIDTH-1:0] w_sram_rd_data;

  // The SRAM read port is shared: RD state owns it during a run, the host
  // only gets it while the block is idle or done.
  assign w_host_rd      = i_read_en && (r_state == IDLE || r_state == DONE);
  assign w_sram_rd_en   = w_host_rd || (r_state == RD);
  assign w_sram_rd_addr = (r_state == RD) ? r_wr_addr : i_read_addr;
  assign w_sram_wr_en   = (r_state == WR) && !i_reg_clear;

  output_sram #(
    .DATA_WIDTH (SRAM_DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_sram (
    .i_clk     (i_clk),
    .i_wr_en   (w_sram_wr_en),
    .i_wr_addr (r_wr_addr),
    .i_wr_data (r_hold),
    .i_rd_en   (w_sram_rd_en),
    .i_rd_addr (w_sram_rd_addr),
    .o_rd_data (w_sram_rd_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    o_psum_ready = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_en) w_state_next = ARMED;
      end
      ARMED: begin
        o_psum_ready = 1'b1;
        o_busy       = 1'b1;
        if (i_psum_valid) w_state_next = r_accum ? RD : WR;
      end
      RD: begin
        o_busy       = 1'b1;
        w_state_next = ADD;
      end
      ADD: begin
        o_busy       = 1'b1;
        w_state_next = WR;
      end
      WR: begin
        o_busy       = 1'b1;
        w_state_next = (r_wr_addr == r_end_addr) ? DONE : ARMED;
      end
      DONE: begin
        o_done = 1'b1;
        if (i_en) w_state_next = ARMED;
      end
      default: w_state_next = IDLE;
    endcase
    if (i_reg_clear) w_state_next = IDLE;
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_accum       <= 1'b0;
      r_wr_addr     <= '0;
      r_end_addr    <= '0;
      r_hold        <= '0;
      r_write_count <= '0;
      r_read_valid  <= 1'b0;
      r_read_last   <= '0;
    end else if (i_reg_clear) begin
      r_accum       <= 1'b0;
      r_wr_addr     <= '0;
      r_end_addr    <= '0;
      r_hold        <= '0;
      r_write_count <= '0;
      r_read_valid  <= 1'b0;
      r_read_last   <= '0;
    end else begin
      r_read_valid <= w_host_rd;
      if (r_read_valid) r_read_last <= w_sram_rd_data;
      unique case (r_state)
        IDLE, DONE: begin
          if (i_en) begin
            r_accum       <= i_accumulate;
            r_wr_addr     <= i_start_addr;
            r_end_addr    <= i_addr_end;
            r_write_count <= '0;
          end
        end
        ARMED: begin
          if (i_psum_valid) r_hold <= i_psum;
        end
        ADD: begin
          r_hold <= lane_add(r_hold, w_sram_rd_data);
        end
        WR: begin
          r_write_count <= r_write_count + (ADDR_WIDTH+1)'(1);
          // Address wraps naturally modulo 2**ADDR_WIDTH.
          if (r_wr_addr != r_end_addr) r_wr_addr <= r_wr_addr + ADDR_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  // Fresh SRAM data is shown in the valid cycle; afterwards the captured copy
  // holds it, so FSM reads during a later run never disturb the host view.
  assign o_read_data   = r_read_valid ? w_sram_rd_data : r_read_last;
  assign o_read_valid  = r_read_valid;
  assign o_write_count = r_write_count;

endmodule

// File: tb/tb_output_router.sv
module tb_output_router;

  localparam int AW = 8;
  localparam int DW = 64;

  logic          i_clk = 1'b0;
  logic          i_nrst;
  logic          i_reg_clear;
  logic          i_en;
  logic          i_accumulate;
  logic [AW-1:0] i_start_addr;
  logic [AW-1:0] i_addr_end;
  logic          i_psum_valid;
  logic [DW-1:0] i_psum;
  logic          o_psum_ready;
  logic          i_read_en;
  logic [AW-1:0] i_read_addr;
  logic [DW-1:0] o_read_data;
  logic          o_read_valid;
  logic          o_busy;
  logic          o_done;
  logic [AW:0]   o_write_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  output_router dut (
    .i_clk         (i_clk),
    .i_nrst        (i_nrst),
    .i_reg_clear   (i_reg_clear),
    .i_en          (i_en),
    .i_accumulate  (i_accumulate),
    .i_start_addr  (i_start_addr),
    .i_addr_end    (i_addr_end),
    .i_psum_valid  (i_psum_valid),
    .i_psum        (i_psum),
    .o_psum_ready  (o_psum_ready),
    .i_read_en     (i_read_en),
    .i_read_addr   (i_read_addr),
    .o_read_data   (o_read_data),
    .o_read_valid  (o_read_valid),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_write_count (o_write_count)
  );

  // Lane k of pattern n is 16'h0100*n + k.
  function automatic logic [DW-1:0] vec(input int n);
    logic [DW-1:0] v;
    for (int k = 0; k < 4; k++) v[k*16 +: 16] = 16'(n * 256 + k);
    return v;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic start_run(input logic acc, input logic [AW-1:0] s, input logic [AW-1:0] e);
    i_en = 1'b1; i_accumulate = acc; i_start_addr = s; i_addr_end = e;
    tick();
    i_en = 1'b0;
  endtask

  // Returns right after the transfer edge.
  task automatic send_vec(input logic [DW-1:0] v);
    bit ok;
    ok = 0;
    i_psum = v; i_psum_valid = 1'b1;
    for (int c = 0; c < 20 && !ok; c++) begin
      if (o_psum_ready) ok = 1;
      tick();
    end
    i_psum_valid = 1'b0;
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL send_timeout: ready=%0b required 1 within 20 cycles", o_psum_ready);
    end
  endtask

  task automatic wait_done(input string tag);
    bit ok;
    ok = 0;
    for (int c = 0; c < 40 && !ok; c++) begin
      if (o_done) ok = 1; else tick();
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s_done_timeout: done=%0b required 1", tag, o_done);
    end
  endtask

  task automatic host_read(input logic [AW-1:0] a, output logic [DW-1:0] d,
                           output logic v_now, output logic v_after);
    i_read_en = 1'b1; i_read_addr = a;
    tick();
    i_read_en = 1'b0;
    v_now = o_read_valid; d = o_read_data;
    tick();
    v_after = o_read_valid;
  endtask

  task automatic test_reset();
    i_nrst = 1'b1;
    #1 i_nrst = 1'b0;
    #2;
    n_vec++;
    if ({o_psum_ready, o_busy, o_done, o_read_valid} !== 4'b0) begin
      n_err++; $display("FAIL reset_flags: got %b required 0000", {o_psum_ready, o_busy, o_done, o_read_valid});
    end
    n_vec++;
    if (o_write_count !== '0) begin
      n_err++; $display("FAIL reset_count: got %0d required 0", o_write_count);
    end
    n_vec++;
    if (o_read_data !== '0) begin
      n_err++; $display("FAIL reset_rdata: got %h required 0", o_read_data);
    end
    repeat (2) @(posedge i_clk);
    #3 i_nrst = 1'b1;
    tick();
  endtask

  task automatic test_overwrite();
    logic [DW-1:0] d; logic v1, v2;
    start_run(1'b0, 8'h10, 8'h13);
    for (int n = 0; n < 4; n++) send_vec(vec(n));
    n_vec++;
    if (o_done !== 1'b0) begin
      n_err++; $display("FAIL ovw_done_early: got %0b required 0", o_done);
    end
    tick();
    n_vec++;
    if ({o_done, o_busy} !== 2'b10) begin
      n_err++; $display("FAIL ovw_done: done,busy got %b required 10", {o_done, o_busy});
    end
    n_vec++;
    if (o_write_count !== 9'd4) begin
      n_err++; $display("FAIL ovw_count: got %0d required 4", o_write_count);
    end
    host_read(8'h12, d, v1, v2);
    n_vec++;
    if (d !== 64'h0203_0202_0201_0200) begin
      n_err++; $display("FAIL ovw_read12: got %h required 0203020202010200", d);
    end
    n_vec++;
    if ({v1, v2} !== 2'b10) begin
      n_err++; $display("FAIL ovw_rvalid_pulse: got %b required 10", {v1, v2});
    end
  endtask

  task automatic test_accumulate();
    logic [DW-1:0] d; logic v1, v2;
    start_run(1'b1, 8'h10, 8'h13);
    for (int n = 0; n < 4; n++) send_vec(64'h0001_0001_0001_0001);
    wait_done("acc");
    n_vec++;
    if (o_write_count !== 9'd4) begin
      n_err++; $display("FAIL acc_count: got %0d required 4", o_write_count);
    end
    host_read(8'h12, d, v1, v2);
    n_vec++;
    if (d !== 64'h0204_0203_0202_0201) begin
      n_err++; $display("FAIL acc_read12: got %h required 0204020302020201", d);
    end
    start_run(1'b1, 8'h10, 8'h10);
    send_vec(64'h0000_0000_0000_FFFF);
    wait_done("acc_wrap");
    host_read(8'h10, d, v1, v2);
    n_vec++;
    if (d !== 64'h0004_0003_0002_0000) begin
      n_err++; $display("FAIL acc_lane_wrap: got %h required 0004000300020000", d);
    end
  endtask

  task automatic test_addr_wrap();
    logic [DW-1:0] d; logic v1, v2;
    logic [AW-1:0] a;
    start_run(1'b0, 8'hFE, 8'h01);
    for (int n = 0; n < 4; n++) send_vec(vec(10 + n));
    wait_done("wrap");
    n_vec++;
    if (o_write_count !== 9'd4) begin
      n_err++; $display("FAIL wrap_count: got %0d required 4", o_write_count);
    end
    for (int n = 0; n < 4; n++) begin
      a = 8'hFE + 8'(n);
      host_read(a, d, v1, v2);
      n_vec++;
      if (d !== vec(10 + n)) begin
        n_err++; $display("FAIL wrap_read_%h: got %h required %h", a, d, vec(10 + n));
      end
    end
    start_run(1'b0, 8'h20, 8'h20);
    send_vec(vec(30));
    tick();
    n_vec++;
    if ({o_done, o_write_count} !== {1'b1, 9'd1}) begin
      n_err++; $display("FAIL single_word: done=%0b count=%0d required done=1 count=1", o_done, o_write_count);
    end
    host_read(8'h20, d, v1, v2);
    n_vec++;
    if (d !== vec(30)) begin
      n_err++; $display("FAIL single_read: got %h required %h", d, vec(30));
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d; logic v1, v2;
    int sent;
    logic r;
    // Overwrite: valid held high, ready alternates.
    start_run(1'b0, 8'h30, 8'h33);
    sent = 0; i_psum = vec(20); i_psum_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      r = o_psum_ready;
      n_vec++;
      if (r !== (i % 2 == 0)) begin
        n_err++; $display("FAIL bp_ovw_ready_c%0d: got %0b required %0b", i, r, (i % 2 == 0));
      end
      tick();
      if (r) begin sent++; i_psum = vec(20 + sent); end
    end
    i_psum_valid = 1'b0;
    n_vec++;
    if ({o_done, o_write_count} !== {1'b1, 9'd4}) begin
      n_err++; $display("FAIL bp_ovw_end: done=%0b count=%0d required done=1 count=4", o_done, o_write_count);
    end
    for (int n = 0; n < 4; n++) begin
      host_read(8'h30 + 8'(n), d, v1, v2);
      n_vec++;
      if (d !== vec(20 + n)) begin
        n_err++; $display("FAIL bp_ovw_read_%0d: got %h required %h", n, d, vec(20 + n));
      end
    end
    // Accumulate: ready one cycle in four.
    start_run(1'b1, 8'h30, 8'h31);
    sent = 0; i_psum = vec(40); i_psum_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      r = o_psum_ready;
      n_vec++;
      if (r !== (i % 4 == 0)) begin
        n_err++; $display("FAIL bp_acc_ready_c%0d: got %0b required %0b", i, r, (i % 4 == 0));
      end
      tick();
      if (r) begin sent++; i_psum = vec(40 + sent); end
    end
    i_psum_valid = 1'b0;
    n_vec++;
    if ({o_done, o_write_count} !== {1'b1, 9'd2}) begin
      n_err++; $display("FAIL bp_acc_end: done=%0b count=%0d required done=1 count=2", o_done, o_write_count);
    end
    host_read(8'h31, d, v1, v2);
    n_vec++;
    if (d !== 64'h3E06_3E04_3E02_3E00) begin
      n_err++; $display("FAIL bp_acc_read31: got %h required 3e063e043e023e00", d);
    end
  endtask

  task automatic test_clear_reset();
    logic [DW-1:0] d; logic v1, v2;
    start_run(1'b0, 8'h40, 8'h41);
    send_vec(vec(50));
    send_vec(vec(51));
    wait_done("clr_pre");
    start_run(1'b1, 8'h40, 8'h41);
    send_vec(vec(7));   // now in RD
    tick();             // now in ADD
    i_reg_clear = 1'b1;
    tick();
    i_reg_clear = 1'b0;
    n_vec++;
    if ({o_busy, o_done, o_psum_ready} !== 3'b000 || o_write_count !== '0) begin
      n_err++; $display("FAIL clear_state: busy,done,ready=%b count=%0d required 000 count=0",
                        {o_busy, o_done, o_psum_ready}, o_write_count);
    end
    host_read(8'h40, d, v1, v2);
    n_vec++;
    if (d !== vec(50) || v1 !== 1'b1) begin
      n_err++; $display("FAIL clear_retained40: got %h valid=%0b required %h valid=1", d, v1, vec(50));
    end
    host_read(8'h41, d, v1, v2);
    n_vec++;
    if (d !== vec(51)) begin
      n_err++; $display("FAIL clear_retained41: got %h required %h", d, vec(51));
    end
    // Async reset in the middle of a run.
    start_run(1'b0, 8'h50, 8'h53);
    send_vec(vec(60));
    tick();             // back in ARMED with one word written
    #2 i_nrst = 1'b0;
    #1;
    n_vec++;
    if ({o_psum_ready, o_busy, o_done, o_read_valid} !== 4'b0 || o_write_count !== '0 || o_read_data !== '0) begin
      n_err++; $display("FAIL async_reset: flags=%b count=%0d rdata=%h required all 0",
                        {o_psum_ready, o_busy, o_done, o_read_valid}, o_write_count, o_read_data);
    end
    #2 i_nrst = 1'b1;
    tick();
  endtask

  task automatic test_illegal();
    logic [DW-1:0] d; logic v1, v2;
    start_run(1'b0, 8'h60, 8'h61);
    i_read_en = 1'b1; i_read_addr = 8'h10;
    tick();
    i_read_en = 1'b0;
    n_vec++;
    if (o_read_valid !== 1'b0) begin
      n_err++; $display("FAIL busy_read_valid: got %0b required 0", o_read_valid);
    end
    i_en = 1'b1; i_accumulate = 1'b1; i_start_addr = 8'h70; i_addr_end = 8'h70;
    tick();
    i_en = 1'b0;
    n_vec++;
    if ({o_busy, o_psum_ready} !== 2'b11) begin
      n_err++; $display("FAIL busy_en_state: busy,ready got %b required 11", {o_busy, o_psum_ready});
    end
    send_vec(vec(80));
    tick();
    n_vec++;
    if ({o_done, o_psum_ready} !== 2'b01) begin
      n_err++; $display("FAIL busy_en_mode: done,ready got %b required 01", {o_done, o_psum_ready});
    end
    send_vec(vec(81));
    tick();
    n_vec++;
    if ({o_done, o_write_count} !== {1'b1, 9'd2}) begin
      n_err++; $display("FAIL busy_en_end: done=%0b count=%0d required done=1 count=2", o_done, o_write_count);
    end
    host_read(8'h60, d, v1, v2);
    n_vec++;
    if (d !== vec(80)) begin
      n_err++; $display("FAIL busy_en_read60: got %h required %h", d, vec(80));
    end
    host_read(8'h61, d, v1, v2);
    n_vec++;
    if (d !== vec(81)) begin
      n_err++; $display("FAIL busy_en_read61: got %h required %h", d, vec(81));
    end
  endtask

  initial begin
    i_reg_clear = 1'b0; i_en = 1'b0; i_accumulate = 1'b0;
    i_start_addr = '0; i_addr_end = '0; i_psum_valid = 1'b0; i_psum = '0;
    i_read_en = 1'b0; i_read_addr = '0;
    test_reset();
    test_overwrite();
    test_accumulate();
    test_addr_wrap();
    test_backpressure();
    test_clear_reset();
    test_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
